// File: rtl/step_counter_7seg_if.sv
// -----------------------------------------------------------------------------
// step_counter_7seg_if
// Bundles the button/direction inputs and the count/display outputs of
// step_counter_7seg so the block drops onto a board wrapper or a bench as one
// port.
//
// Parameters: WIDTH (count width), DIGITS (number of seven-segment digits).
// Signals:
//   select_button  raw asynchronous push-button level
//   dir            1 = count up, 0 = count down
//   count          current count value
//   count_reached  high while count equals the wrap limit
//   seg            7 bits per digit, digit 0 (units) in seg[6:0], {g,f,e,d,c,b,a}
//   bcd_busy       high while a binary-to-BCD conversion is in progress
//   bcd_state      debug view of the converter FSM state (0 idle, 1 shift, 2 done)
// Modports: master drives the inputs (board/bench), slave is the counter.
// -----------------------------------------------------------------------------
interface step_counter_7seg_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  select_button;
    logic                  dir;
    logic [WIDTH-1:0]      count;
    logic                  count_reached;
    logic [7*DIGITS-1:0]   seg;
    logic                  bcd_busy;
    logic [1:0]            bcd_state;

    modport master (
        output select_button,
        output dir,
        input  count,
        input  count_reached,
        input  seg,
        input  bcd_busy,
        input  bcd_state
    );

    modport slave (
        input  select_button,
        input  dir,
        output count,
        output count_reached,
        output seg,
        output bcd_busy,
        output bcd_state
    );
endinterface

// File: rtl/step_counter_7seg.sv
// -----------------------------------------------------------------------------
// step_counter_7seg
// Debounced push-button step counter with up/down mode, programmable wrap
// limit and a multi-digit seven-segment display driven through a sequential
// shift-and-add-3 binary-to-BCD converter.
//
// Ports:
//   clk    single clock for all state
//   reset  asynchronous, active-low reset; deassertion is synchronised
//   bus    step_counter_7seg_if.slave (select_button, dir, count,
//          count_reached, seg, bcd_busy, bcd_state)
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          nonzero digit are blanked (00); the units digit
//                          always displays. When undefined, leading zeros
//                          show as 0 (3F).
//
// Press semantics: a press is a single-cycle pulse produced on the debounced
// 0->1 edge of the button; it is consumed on the same cycle by the count
// register (there is no backpressure, a press is never held pending).
// -----------------------------------------------------------------------------
module step_counter_7seg #(
    parameter int WIDTH           = 8,
    parameter int STEP            = 10,
    parameter int LIMIT           = 150,
    parameter int DIGITS          = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    step_counter_7seg_if.slave   bus
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int SEG_W  = 7 * DIGITS;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ITER_W = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
    localparam logic [WIDTH:0]   LIMIT_X = (WIDTH+1)'(LIMIT);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // -------------------------------------------------------------------------
    // Seven-segment helpers
    // -------------------------------------------------------------------------
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Display pattern for an all-zero digit register, i.e. the value "0".
    function automatic logic [SEG_W-1:0] seg_reset_val();
        logic [SEG_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            r[7*i +: 7] = (i == 0) ? 7'h3F : 7'h00;
`else
            r[7*i +: 7] = 7'h3F;
`endif
        end
        return r;
    endfunction

    localparam logic [SEG_W-1:0] SEG_RST = seg_reset_val();

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 so the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Reset: asserts asynchronously, releases two clocks after reset rises.
    // -------------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // -------------------------------------------------------------------------
    // Button conditioning: 2-flop synchroniser followed by a debounce counter
    // -------------------------------------------------------------------------
    logic [1:0]      btn_sync;
    logic            btn_level;
    logic            btn_level_prev;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= 2'b00;
        end else begin
            btn_sync <= {btn_sync[0], bus.select_button};
        end
    end

    // The debounced level flips only after DEBOUNCE_CYCLES consecutive
    // synchronised samples disagree with it; one agreeing sample restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level      <= 1'b0;
            btn_level_prev <= 1'b0;
            db_cnt         <= '0;
        end else begin
            btn_level_prev <= btn_level;
            if (btn_sync[1] != btn_level) begin
                if (db_cnt == DB_LAST) begin
                    btn_level <= btn_sync[1];
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Rising edge of the debounced level only; release produces nothing.
    assign press = btn_level & ~btn_level_prev;

    // -------------------------------------------------------------------------
    // Count register
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] count_q;
    logic [WIDTH:0]   sum_up;

    // One extra bit so count + STEP cannot wrap before the limit compare.
    assign sum_up = {1'b0, count_q} + {1'b0, STEP_V};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (press) begin
            if (bus.dir) begin
                if (sum_up > LIMIT_X) begin
                    count_q <= '0;
                end else begin
                    count_q <= sum_up[WIDTH-1:0];
                end
            end else begin
                if (count_q < STEP_V) begin
                    count_q <= LIMIT_V;
                end else begin
                    count_q <= count_q - STEP_V;
                end
            end
        end
    end

    assign bus.count         = count_q;
    assign bus.count_reached = (count_q == LIMIT_V);

    // -------------------------------------------------------------------------
    // Binary-to-BCD converter FSM
    // -------------------------------------------------------------------------
    bcd_state_t                 state_q, state_d;
    logic [WIDTH-1:0]           last_q, last_d;    // value last taken for conversion
    logic [WIDTH-1:0]           bin_q, bin_d;      // binary shift register
    logic [BCD_W-1:0]           bcd_q, bcd_d;      // BCD accumulator
    logic [ITER_W-1:0]          iter_q, iter_d;
    logic [DIGITS-1:0][3:0]     digit_q, digit_d;  // displayed digits
    logic [BCD_W+WIDTH-1:0]     shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        digit_d = digit_q;
        shifted = {add3(bcd_q), bin_q} << 1;

        case (state_q)
            IDLE: begin
                // A count change that happened mid-conversion is caught here
                // on return, so the display always converges on the count.
                if (count_q != last_q) begin
                    last_d  = count_q;
                    bin_d   = count_q;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d  = shifted[BCD_W+WIDTH-1 -: BCD_W];
                bin_d  = shifted[WIDTH-1:0];
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                digit_d = bcd_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.bcd_busy  = (state_q != IDLE);
    assign bus.bcd_state = state_q;

    // -------------------------------------------------------------------------
    // Seven-segment output register
    // -------------------------------------------------------------------------
    logic [SEG_W-1:0] seg_d, seg_q;

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic leading;
        leading = 1'b1;
        seg_d   = '0;
        // Walk from the most significant digit down; while every digit seen
        // so far is zero the digit is a leading zero and stays dark.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            leading = leading & (digit_q[i] == 4'd0);
            if (i != 0 && leading) begin
                seg_d[7*i +: 7] = 7'h00;
            end else begin
                seg_d[7*i +: 7] = seg_enc(digit_q[i]);
            end
        end
    end
`else
    always_comb begin
        seg_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_d[7*i +: 7] = seg_enc(digit_q[i]);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_RST;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign bus.seg = seg_q;

endmodule

// File: tb/tb_step_counter_7seg.sv
// -----------------------------------------------------------------------------
// tb_step_counter_7seg
// Self-checking bench for step_counter_7seg with default parameters. A count
// model computed from the counting rules feeds an expected queue that a monitor
// compares against every observed count change; the display is predicted with
// decimal arithmetic and the segment table.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_step_counter_7seg;

    localparam int WIDTH  = 8;
    localparam int STEP   = 10;
    localparam int LIMIT  = 150;
    localparam int DIGITS = 3;
    localparam int DEB    = 4;

    localparam logic [6:0] SEG_LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    step_counter_7seg_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    step_counter_7seg #(
        .WIDTH(WIDTH), .STEP(STEP), .LIMIT(LIMIT),
        .DIGITS(DIGITS), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    int model_count = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] prev_count = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int next_count(input int c, input bit up);
        if (up) return (c + STEP > LIMIT) ? 0 : c + STEP;
        else    return (c < STEP) ? LIMIT : c - STEP;
    endfunction

    function automatic logic [31:0] seg_of(input int v);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            bit blank;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (i > 0) && (v < p);
`else
            blank = 1'b0;
`endif
            r[7*i +: 7] = blank ? 7'h00 : SEG_LUT[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    // Every count change outside reset must be the next expected value.
    always @(negedge clk) begin
        if (!reset) begin
            prev_count <= bus.count;
        end else if (bus.count !== prev_count) begin
            if (exp_q.size() == 0) begin
                check("unexpected_count_change", {24'd0, bus.count}, {24'd0, prev_count});
            end else begin
                check("count_step", {24'd0, bus.count}, {24'd0, exp_q.pop_front()});
            end
            prev_count <= bus.count;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic accept(input bit up, input int hold);
        if (hold >= DEB) begin
            model_count = next_count(model_count, up);
            exp_q.push_back(WIDTH'(model_count));
        end
    endtask

    task automatic press(input bit up, input int hold, input int gap);
        @(negedge clk);
        bus.dir = up;
        accept(up, hold);
        bus.select_button = 1'b1;
        repeat (hold) @(negedge clk);
        bus.select_button = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic settle_check(input string tag);
        repeat (30) @(negedge clk);
        check({tag, "_count"},   {24'd0, bus.count}, model_count);
        check({tag, "_reached"}, {31'd0, bus.count_reached}, (model_count == LIMIT) ? 1 : 0);
        check({tag, "_seg"},     {11'd0, bus.seg}, seg_of(model_count));
        check({tag, "_busy"},    {31'd0, bus.bcd_busy}, 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"},   {24'd0, bus.count}, 0);
        check({tag, "_reached"}, {31'd0, bus.count_reached}, 0);
        check({tag, "_busy"},    {31'd0, bus.bcd_busy}, 0);
        check({tag, "_state"},   {30'd0, bus.bcd_state}, 0);
        check({tag, "_seg"},     {11'd0, bus.seg}, seg_of(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int old_count;
        int elapsed;
        bit seen;
        reset = 1'b0;
        bus.select_button = 1'b0;
        bus.dir = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_values("after_reset");

        // Held button: exactly one step, then display latency of WIDTH+3.
        old_count = model_count;
        bus.dir = 1'b1;
        accept(1'b1, 20);
        bus.select_button = 1'b1;
        elapsed = 0;
        seen = 1'b0;
        while (!seen && elapsed < 20) begin
            @(negedge clk);
            elapsed++;
            if (bus.count !== WIDTH'(old_count)) seen = 1'b1;
        end
        check("held_count_change_seen", {31'd0, seen}, 1);
        repeat (WIDTH + 2) @(negedge clk);
        check("seg_before_latency", {11'd0, bus.seg}, seg_of(old_count));
        @(negedge clk);
        check("seg_at_latency", {11'd0, bus.seg}, seg_of(model_count));
        elapsed += WIDTH + 3;
        if (elapsed < 20) repeat (20 - elapsed) @(negedge clk);
        bus.select_button = 1'b0;
        settle_check("held");

        // Two-cycle glitch: no step, no conversion activity.
        press(1'b1, 2, 0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.bcd_busy) seen = 1'b1;
        end
        check("glitch_no_busy", {31'd0, seen}, 0);
        settle_check("glitch");

        // Three samples is still one short of the debounce threshold.
        press(1'b1, 3, 0);
        settle_check("short3");

        // Climb to the limit with minimum-length accepted presses, then wrap.
        while (model_count < LIMIT) begin
            press(1'b1, DEB, 0);
            settle_check("climb");
        end
        press(1'b1, 8, 0);
        settle_check("wrap_up");

        // Down wraps to the limit, then steps down.
        press(1'b0, 8, 0);
        settle_check("wrap_down");
        press(1'b0, 8, 0);
        settle_check("down_step");

        // Second press lands while the first conversion is running.
        press(1'b0, 5, 6);
        press(1'b0, 5, 0);
        settle_check("close_pair");

        // Randomised presses with hold lengths around the threshold.
        repeat (40) begin
            press(1'($urandom_range(0, 1)), $urandom_range(1, 12), 0);
            settle_check("rand");
        end

        // Reset in the middle of a conversion.
        if (model_count == LIMIT) press(1'b0, 6, 0);
        press(1'b1, 6, 0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (!seen && bus.bcd_state == 2'd1) seen = 1'b1;
            if (seen) break;
        end
        check("shift_seen_before_reset", {31'd0, seen}, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        model_count = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.bcd_busy) seen = 1'b1;
        end
        check("no_conversion_after_reset", {31'd0, seen}, 0);
        check_reset_values("post_reset");
        press(1'b1, 6, 0);
        settle_check("after_reset_press");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
